// File: rtl/complex_op_sequencer_if.sv
`default_nettype none
// ============================================================================
// complex_op_sequencer_if : word stream, operand bundle and result handshakes
// Revision: 1.0
// ============================================================================
interface complex_op_sequencer_if;
    logic [63:0]       word_i;
    logic              word_valid_i;
    logic              word_ready_o;
    logic [3:0][63:0]  op_operands_o;
    logic              op_valid_o;
    logic              op_ready_i;
    logic [1:0][63:0]  op_result_i;
    logic [4:0]        op_status_i;
    logic              op_res_valid_i;
    logic              op_res_ready_o;
    logic [63:0]       res_word_o;
    logic              res_valid_o;
    logic              res_ready_i;

    // master: the sequencer itself; slave: load/store stream and complex unit side
    modport master (
        input  word_i, word_valid_i, op_ready_i, op_result_i, op_status_i,
               op_res_valid_i, res_ready_i,
        output word_ready_o, op_operands_o, op_valid_o, op_res_ready_o,
               res_word_o, res_valid_o
    );

    modport slave (
        output word_i, word_valid_i, op_ready_i, op_result_i, op_status_i,
               op_res_valid_i, res_ready_i,
        input  word_ready_o, op_operands_o, op_valid_o, op_res_ready_o,
               res_word_o, res_valid_o
    );
endinterface
`default_nettype wire

// File: rtl/complex_op_sequencer.sv
`default_nettype none
// ============================================================================
// complex_op_sequencer : packs FP64 words into complex operand bundles, issues
// them under credit control and serialises the buffered results back to words.
// Revision: 1.0
// ============================================================================
module complex_op_sequencer #(
    parameter  int RES_DEPTH = 4,
    localparam int CW        = $clog2(RES_DEPTH + 1)
) (
    input  wire logic                clk_i,
    input  wire logic                rst_ni,
    input  wire logic                flush_i,
    input  wire logic                status_clr_i,
    complex_op_sequencer_if.master   bus,
    output logic                     op_flush_o,
    output logic [4:0]               status_o,
    output logic [CW-1:0]            outstanding_o,
    output logic                     busy_o
);
    localparam int              PW      = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam logic [CW-1:0]   C_DEPTH = CW'(RES_DEPTH);
    localparam logic [PW-1:0]   C_LAST  = PW'(RES_DEPTH - 1);

    typedef enum logic [2:0] {
        S_GA1   = 3'd0,
        S_GB1   = 3'd1,
        S_GA2   = 3'd2,
        S_GB2   = 3'd3,
        S_ISSUE = 3'd4
    } state_t;

    state_t             r_state;
    logic [3:0][63:0]   r_operands;
    logic [CW-1:0]      r_credits;
    logic [CW-1:0]      r_count;
    logic [PW-1:0]      r_wptr;
    logic [PW-1:0]      r_rptr;
    logic               r_half;
    logic [4:0]         r_status;
    logic [63:0]        r_fifo_re [RES_DEPTH];
    logic [63:0]        r_fifo_im [RES_DEPTH];

    logic w_word_hs, w_op_hs, w_push, w_push_keep, w_drain, w_pop;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == C_LAST) ? '0 : p + 1'b1;
    endfunction

    assign bus.word_ready_o   = (r_state != S_ISSUE);
    assign bus.op_valid_o     = (r_state == S_ISSUE) && (r_credits < C_DEPTH);
    assign bus.op_operands_o  = r_operands;
    assign bus.op_res_ready_o = (r_count != C_DEPTH);
    assign bus.res_valid_o    = (r_count != '0);
    assign bus.res_word_o     = r_half ? r_fifo_im[r_rptr] : r_fifo_re[r_rptr];

    assign w_word_hs   = bus.word_valid_i & bus.word_ready_o;
    assign w_op_hs     = bus.op_valid_o & bus.op_ready_i;
    assign w_push      = bus.op_res_valid_i & bus.op_res_ready_o;
    assign w_push_keep = w_push & ~flush_i;
    assign w_drain     = bus.res_valid_o & bus.res_ready_i;
    assign w_pop       = w_drain & r_half;

    assign op_flush_o    = flush_i;
    assign status_o      = r_status;
    assign outstanding_o = r_credits;
    assign busy_o        = (r_state != S_GA1) || (r_credits != '0);

    // Gather FSM and credit counter; a credit returns only when the imag word leaves
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_GA1;
            r_operands <= '0;
            r_credits  <= '0;
        end else if (flush_i) begin
            r_state   <= S_GA1;
            r_credits <= '0;
        end else begin
            unique case (r_state)
                S_GA1:   if (w_word_hs) begin r_operands[0] <= bus.word_i; r_state <= S_GB1; end
                S_GB1:   if (w_word_hs) begin r_operands[1] <= bus.word_i; r_state <= S_GA2; end
                S_GA2:   if (w_word_hs) begin r_operands[2] <= bus.word_i; r_state <= S_GB2; end
                S_GB2:   if (w_word_hs) begin r_operands[3] <= bus.word_i; r_state <= S_ISSUE; end
                S_ISSUE: if (w_op_hs) r_state <= S_GA1;
                default: r_state <= S_GA1;
            endcase
            if (w_op_hs && !w_pop)
                r_credits <= r_credits + 1'b1;
            else if (!w_op_hs && w_pop && (r_credits != '0))
                r_credits <= r_credits - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_half  <= 1'b0;
        end else if (flush_i) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_half  <= 1'b0;
        end else begin
            if (w_push) r_wptr <= f_next(r_wptr);
            if (w_pop)  r_rptr <= f_next(r_rptr);
            if (w_drain) r_half <= ~r_half;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!w_push && w_pop)
                r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push_keep) begin
            r_fifo_re[r_wptr] <= bus.op_result_i[0];
            r_fifo_im[r_wptr] <= bus.op_result_i[1];
        end
    end

    // Flush deliberately leaves the sticky flags alone
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_status <= '0;
        else if (status_clr_i)
            r_status <= w_push_keep ? bus.op_status_i : 5'd0;
        else if (w_push_keep)
            r_status <= r_status | bus.op_status_i;
    end
endmodule
`default_nettype wire
